// File: rtl/logic_op_pkg.sv
// Shared operator codes and FSM state encoding for the logic_op_array slice.
package logic_op_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_XNOR = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SWAP  = 2'd2
  } state_t;

endpackage

// File: rtl/logic_op_array_if.sv
// Valid/ready stream bundle: operand beats in, result beats out.
interface logic_op_array_if #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 1
);
  logic                      s_valid;
  logic                      s_ready;
  logic [CHANNELS*WIDTH-1:0] s_a;
  logic [CHANNELS*WIDTH-1:0] s_b;
  logic                      m_valid;
  logic                      m_ready;
  logic [CHANNELS*WIDTH-1:0] m_out;

  modport master (
    output s_valid, s_a, s_b, m_ready,
    input  s_ready, m_valid, m_out
  );

  modport slave (
    input  s_valid, s_a, s_b, m_ready,
    output s_ready, m_valid, m_out
  );
endinterface

// File: rtl/logic_op_lane.sv
// One lane of the array: bitwise operator selected by op.
module logic_op_lane
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_op_array.sv
// N-lane bitwise logic unit: 2-stage valid/ready pipeline with shadowed
// per-lane operators that swap in only once the pipeline has drained.
module logic_op_array
  import logic_op_pkg::*;
#(
  parameter int  CHANNELS   = 2,
  parameter int  WIDTH      = 1,
  parameter op_t DEFAULT_OP = OP_AND,
  localparam int CHW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_we,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [1:0]     cfg_op,
  input  logic           commit,
  output logic           busy,
  logic_op_array_if.slave bus
);

  localparam int DW = CHANNELS * WIDTH;

  state_t          r_state;
  state_t          w_state_nxt;
  op_t             r_op_shd [CHANNELS];
  op_t             r_op_act [CHANNELS];
  logic            r_v1;
  logic            r_v2;
  logic [DW-1:0]   r_a;
  logic [DW-1:0]   r_b;
  logic [DW-1:0]   r_res;
  logic [DW-1:0]   w_res;
  logic            w_en;
  logic            w_swap;

  assign w_en        = !r_v2 || bus.m_ready;
  assign bus.s_ready = w_en && (r_state == ST_RUN);
  assign bus.m_valid = r_v2;
  assign bus.m_out   = r_res;
  assign busy        = (r_state != ST_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_swap      = 1'b0;
    case (r_state)
      ST_RUN:   if (commit) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (!r_v1 && !r_v2) w_state_nxt = ST_SWAP;
      ST_SWAP: begin
        w_swap      = 1'b1;
        w_state_nxt = ST_RUN;
      end
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  // A write landing in the SWAP cycle reaches the shadow only: the active
  // copy samples the pre-write shadow value on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        r_op_shd[i] <= DEFAULT_OP;
        r_op_act[i] <= DEFAULT_OP;
      end
    end else begin
      if (w_swap) begin
        for (int unsigned i = 0; i < CHANNELS; i++) r_op_act[i] <= r_op_shd[i];
      end
      if (cfg_we && (int'(cfg_ch) < CHANNELS)) r_op_shd[cfg_ch] <= op_t'(cfg_op);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
    end else if (w_en) begin
      r_v1  <= bus.s_valid && bus.s_ready;
      r_a   <= bus.s_a;
      r_b   <= bus.s_b;
      r_v2  <= r_v1;
      r_res <= w_res;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    logic_op_lane #(.WIDTH(WIDTH)) u_lane (
      .op (r_op_act[c]),
      .a  (r_a[c*WIDTH +: WIDTH]),
      .b  (r_b[c*WIDTH +: WIDTH]),
      .y  (w_res[c*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_logic_op_array.sv
// Directed bench for logic_op_array: reset, ops, commit/drain, backpressure.
module tb_logic_op_array;
  import logic_op_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       cfg_we, commit, busy;
  logic [0:0] cfg_ch;
  logic [1:0] cfg_op;
  logic       c3_we, c3_commit, c3_busy;
  logic [1:0] c3_ch, c3_op;

  logic_op_array_if #(.CHANNELS(2), .WIDTH(4)) bus ();
  logic_op_array_if #(.CHANNELS(3), .WIDTH(4)) bus3 ();

  logic_op_array #(.CHANNELS(2), .WIDTH(4), .DEFAULT_OP(OP_AND)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_op(cfg_op),
    .commit(commit), .busy(busy), .bus(bus)
  );

  logic_op_array #(.CHANNELS(3), .WIDTH(4), .DEFAULT_OP(OP_OR)) dut3 (
    .clk(clk), .rst(rst), .cfg_we(c3_we), .cfg_ch(c3_ch), .cfg_op(c3_op),
    .commit(c3_commit), .busy(c3_busy), .bus(bus3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cfg_we = 0; cfg_ch = '0; cfg_op = '0; commit = 0;
    c3_we = 0; c3_ch = '0; c3_op = '0; c3_commit = 0;
    bus.s_valid = 0; bus.s_a = '0; bus.s_b = '0; bus.m_ready = 1;
    bus3.s_valid = 0; bus3.s_a = '0; bus3.s_b = '0; bus3.m_ready = 1;
    #2;
    n_tests++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got %b want 0", bus.m_valid); end
    n_tests++; if (bus.m_out !== 8'h00) begin n_fail++; $display("FAIL reset_m_out got %h want 00", bus.m_out); end
    tick(); tick();
    rst = 0;
    #1;
    n_tests++; if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready got %b want 1", bus.s_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_basic();
    tick();
    bus.s_valid = 1; bus.s_a = 8'h3C; bus.s_b = 8'hFA;
    #1;
    n_tests++; if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL basic_s_ready got %b want 1", bus.s_ready); end
    tick();
    bus.s_valid = 0;
    #1;
    n_tests++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL basic_lat1 got %b want 0", bus.m_valid); end
    tick(); #1;
    n_tests++; if (bus.m_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b want 1", bus.m_valid); end
    n_tests++; if (bus.m_out !== 8'h38) begin n_fail++; $display("FAIL basic_and got %h want 38", bus.m_out); end
    tick(); #1;
    n_tests++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL basic_gone got %b want 0", bus.m_valid); end
  endtask

  task automatic test_commit_empty();
    tick();
    cfg_we = 1; cfg_ch = 1'b0; cfg_op = OP_XOR;
    tick();
    cfg_ch = 1'b1; cfg_op = OP_OR; commit = 1;
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ce_busy0 got %b want 0", busy); end
    tick();
    cfg_we = 0; commit = 0;
    #1;
    n_tests++; if (busy !== 1'b1 || bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL ce_drain busy=%b s_ready=%b want 1/0", busy, bus.s_ready); end
    tick(); #1;
    n_tests++; if (busy !== 1'b1 || bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL ce_swap busy=%b s_ready=%b want 1/0", busy, bus.s_ready); end
    tick();
    bus.s_valid = 1; bus.s_a = 8'h3C; bus.s_b = 8'hFA;
    #1;
    n_tests++; if (busy !== 1'b0 || bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL ce_run busy=%b s_ready=%b want 0/1", busy, bus.s_ready); end
    tick();
    bus.s_valid = 0;
    tick(); #1;
    n_tests++; if (bus.m_valid !== 1'b1 || bus.m_out !== 8'hF6) begin n_fail++; $display("FAIL ce_newops got v=%b %h want 1 F6", bus.m_valid, bus.m_out); end
  endtask

  task automatic test_stream_commit();
    logic [7:0] va [4];
    logic [7:0] vb [4];
    logic [7:0] ve [4];
    int in_i, out_i, low;
    bit acc, committed;
    va = '{8'h3C, 8'h0F, 8'hA5, 8'hFF};
    vb = '{8'hFA, 8'h55, 8'h3C, 8'h00};
    ve = '{8'hF6, 8'h5A, 8'h64, 8'h00};
    in_i = 0; out_i = 0; low = 0; committed = 0;
    tick();
    cfg_we = 1; cfg_ch = 1'b0; cfg_op = OP_AND;
    tick();
    cfg_ch = 1'b1; cfg_op = OP_XNOR;
    for (int cyc = 0; cyc < 40 && out_i < 4; cyc++) begin
      tick();
      cfg_we = 0;
      bus.s_valid = (in_i < 4);
      if (in_i < 4) begin bus.s_a = va[in_i]; bus.s_b = vb[in_i]; end
      commit = (in_i == 1) && !committed;
      #1;
      acc = bus.s_valid && bus.s_ready;
      if (commit) committed = 1;
      if (in_i < 4 && !bus.s_ready) low++;
      if (bus.m_valid) begin
        n_tests++; if (bus.m_out !== ve[out_i]) begin n_fail++; $display("FAIL stream_beat%0d got %h want %h", out_i, bus.m_out, ve[out_i]); end
        out_i++;
      end
      if (acc) in_i++;
    end
    commit = 0;
    bus.s_valid = 0;
    n_tests++; if (out_i !== 4) begin n_fail++; $display("FAIL stream_count got %0d want 4", out_i); end
    n_tests++; if (low !== 4) begin n_fail++; $display("FAIL stream_stall got %0d want 4", low); end
    tick(); #1;
    n_tests++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL stream_extra got %b want 0", bus.m_valid); end
  endtask

  task automatic test_backpressure();
    tick();
    bus.m_ready = 0;
    bus.s_valid = 1; bus.s_a = 8'h12; bus.s_b = 8'h34;
    #1;
    n_tests++; if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL bp_acc0 got %b want 1", bus.s_ready); end
    tick();
    bus.s_a = 8'hF0; bus.s_b = 8'hF0;
    #1;
    n_tests++; if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL bp_acc1 got %b want 1", bus.s_ready); end
    tick();
    bus.s_a = 8'h66; bus.s_b = 8'h0F;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      #1;
      n_tests++;
      if (bus.m_valid !== 1'b1 || bus.m_out !== 8'hD0 || bus.s_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold%0d v=%b out=%h s_ready=%b want 1 D0 0", i, bus.m_valid, bus.m_out, bus.s_ready);
      end
    end
    tick();
    bus.m_ready = 1;
    #1;
    n_tests++; if (bus.m_out !== 8'hD0 || bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL bp_rel out=%h s_ready=%b want D0 1", bus.m_out, bus.s_ready); end
    tick();
    bus.s_valid = 0;
    #1;
    n_tests++; if (bus.m_valid !== 1'b1 || bus.m_out !== 8'hF0) begin n_fail++; $display("FAIL bp_second v=%b out=%h want 1 F0", bus.m_valid, bus.m_out); end
    tick(); #1;
    n_tests++; if (bus.m_valid !== 1'b1 || bus.m_out !== 8'h96) begin n_fail++; $display("FAIL bp_third v=%b out=%h want 1 96", bus.m_valid, bus.m_out); end
    tick(); #1;
    n_tests++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got %b want 0", bus.m_valid); end
  endtask

  task automatic test_swap_write();
    tick();
    commit = 1;
    tick();
    commit = 0;
    #1;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL sw_drain got %b want 1", busy); end
    tick();
    cfg_we = 1; cfg_ch = 1'b0; cfg_op = OP_OR;
    #1;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL sw_swap got %b want 1", busy); end
    tick();
    cfg_we = 0;
    bus.s_valid = 1; bus.s_a = 8'h3C; bus.s_b = 8'hFA;
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sw_run got %b want 0", busy); end
    tick();
    bus.s_valid = 0;
    tick(); #1;
    n_tests++; if (bus.m_out !== 8'h38) begin n_fail++; $display("FAIL sw_notyet got %h want 38", bus.m_out); end
    tick();
    commit = 1;
    tick();
    commit = 0;
    tick();
    tick();
    bus.s_valid = 1;
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sw_run2 got %b want 0", busy); end
    tick();
    bus.s_valid = 0;
    tick(); #1;
    n_tests++; if (bus.m_valid !== 1'b1 || bus.m_out !== 8'h3E) begin n_fail++; $display("FAIL sw_applied v=%b out=%h want 1 3E", bus.m_valid, bus.m_out); end
  endtask

  task automatic test_out_of_range();
    tick();
    c3_we = 1; c3_ch = 2'd3; c3_op = OP_XOR; c3_commit = 1;
    tick();
    c3_we = 0; c3_commit = 0;
    tick();
    tick();
    bus3.s_valid = 1; bus3.s_a = 12'h5C3; bus3.s_b = 12'h9A6;
    #1;
    n_tests++; if (c3_busy !== 1'b0 || bus3.s_ready !== 1'b1) begin n_fail++; $display("FAIL oob_run busy=%b s_ready=%b want 0 1", c3_busy, bus3.s_ready); end
    tick();
    bus3.s_valid = 0;
    tick(); #1;
    n_tests++; if (bus3.m_valid !== 1'b1 || bus3.m_out !== 12'hDE7) begin n_fail++; $display("FAIL oob_ops v=%b out=%h want 1 DE7", bus3.m_valid, bus3.m_out); end
  endtask

  task automatic test_reset_drain();
    tick();
    bus.m_ready = 0;
    bus.s_valid = 1; bus.s_a = 8'h3C; bus.s_b = 8'hFA;
    tick();
    commit = 1;
    tick();
    bus.s_valid = 0; commit = 0;
    cfg_we = 1; cfg_ch = 1'b1; cfg_op = OP_XOR;
    #1;
    n_tests++; if (busy !== 1'b1 || bus.m_valid !== 1'b1) begin n_fail++; $display("FAIL rd_full busy=%b v=%b want 1 1", busy, bus.m_valid); end
    #2;
    rst = 1;
    #1;
    cfg_we = 0;
    n_tests++; if (bus.m_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rd_async v=%b busy=%b want 0 0", bus.m_valid, busy); end
    tick();
    tick();
    rst = 0;
    bus.m_ready = 1;
    bus.s_valid = 1; bus.s_a = 8'h3C; bus.s_b = 8'hFA;
    #1;
    n_tests++; if (bus.s_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rd_release s_ready=%b busy=%b want 1 0", bus.s_ready, busy); end
    tick();
    bus.s_valid = 0;
    #1;
    n_tests++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL rd_discard got %b want 0", bus.m_valid); end
    tick(); #1;
    n_tests++; if (bus.m_valid !== 1'b1 || bus.m_out !== 8'h38) begin n_fail++; $display("FAIL rd_default v=%b out=%h want 1 38", bus.m_valid, bus.m_out); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_commit_empty();
    test_stream_commit();
    test_backpressure();
    test_swap_write();
    test_out_of_range();
    test_reset_drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
